multi_debounce_one_shot: RTL and testbench
==========================================

# multi_debounce_one_shot

Parametrised N-channel button conditioner: synchronises raw push-button inputs, debounces each channel with a stability counter, and emits single-cycle pulses on selected edges, with optional hold-to-repeat. It is the drop-in replacement for the single-channel one-shot. It sits between board push-buttons/switches and the control FSMs that consume `*_pulse` strobes.

## Interface
- `N_CH`, 4: number of independent channels.
- `DB_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 1.
- `EDGE_MODE`, 0: pulse source. 0 = press (rising debounced), 1 = release (falling), 2 = both.
- `ACTIVE_LOW`, 1: 1 = raw input low means pressed, so the input is inverted after synchronisation.
- `REPEAT_EN`, 0: 1 enables hold-to-repeat pulses.
- `REPEAT_DELAY`, 25000000: held cycles after the press pulse before the first repeat pulse.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `button` input `N_CH`: raw asynchronous button inputs.
- `button_level` output `N_CH`: debounced, polarity-normalised level (1 = pressed).
- `button_one_shot` output `N_CH`: one-cycle pulse per qualifying event.

## Operation
- Reset (async, while `rst_n` = 0) clears the following to 0: synchroniser flops, `button_level`, `button_one_shot`, all counters, and every channel FSM, which goes to IDLE.
- Synchronisation: 2-flop synchroniser per channel. After it, apply the `ACTIVE_LOW` inversion to get `s[i]`.
- Debounce:
  - Counter `db_cnt` has width `$clog2(DB_CYCLES+1)`.
  - If `s[i] == button_level[i]`, `db_cnt` clears to 0.
  - Otherwise it increments.
  - When it would reach `DB_CYCLES`, `button_level[i]` toggles and `db_cnt` clears on the same edge.
  - Any bounce back before then restarts the count.
- Edge pulse: `button_one_shot[i]` is registered and asserts on the same edge that `button_level[i]` toggles, if the edge matches `EDGE_MODE`. It deasserts on the next edge.
- Repeat FSM, per channel, active only when `REPEAT_EN` = 1 and `EDGE_MODE` ≠ 1. States are IDLE, HOLD and REPEAT.
  - IDLE → HOLD on the press toggle; `rp_cnt` cleared.
  - In HOLD, `rp_cnt` counts. At `REPEAT_DELAY` it emits a pulse, clears `rp_cnt`, and moves to REPEAT.
  - In REPEAT, it emits a pulse each time `rp_cnt` reaches `REPEAT_PERIOD`, then clears `rp_cnt`.
  - Release toggle from HOLD or REPEAT → IDLE and clears `rp_cnt`. No repeat pulse is emitted on the release edge.
  - `rp_cnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.
- Pulse merging: per channel, pulse = edge pulse OR repeat pulse. They cannot coincide, because repeats occur only while level = 1 with no toggle.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.

## Timing
- Latency from a raw change to the `button_level`/`button_one_shot` edge is 2 + `DB_CYCLES` clock edges, provided the input is stable throughout.
- A pulse is exactly 1 cycle wide, with at most one pulse per channel per event.
- The first repeat pulse comes `REPEAT_DELAY` cycles after the press pulse. Later repeats come every `REPEAT_PERIOD` cycles.
- A glitch shorter than `DB_CYCLES` synchronised cycles produces no level change and no pulse.
- `rst_n` asserted mid-count or mid-repeat: outputs drop to 0 immediately, asynchronously.
- After `rst_n` deassertion with a button held: treated as a new press. The pulse appears after 2 + `DB_CYCLES` edges.

## Structure
- Package `button_pkg`:
  - edge-mode constants `EDGE_RISE` = 0, `EDGE_FALL` = 1, `EDGE_BOTH` = 2;
  - repeat FSM state encoding (IDLE/HOLD/REPEAT, 2 bits).
- Sub-module `debounce_channel`: synchroniser, debounce counter, edge detect and repeat FSM for one channel. The top generates `N_CH` instances and concatenates their outputs.

## Test plan
Use `DB_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, `ACTIVE_LOW`=0, `N_CH`=4.
- Clean press: ch0 goes 0→1 and is held 20 cycles → `button_level[0]` rises and `button_one_shot[0]` is high for exactly 1 cycle, both 6 edges after the input change; no other pulse occurs.
- Bounce: ch1 toggles 1,0,1,0 every 2 cycles, then holds 1 → one pulse, 6 edges after the final rise; no earlier level change.
- `EDGE_MODE`=2: press then release on ch2, each held 10 cycles → two 1-cycle pulses, one per debounced edge.
- Repeat, with `REPEAT_EN`=1: hold ch3 for 40 cycles → pulses at press + 0, +10, +15, +20, ... until release; none after the release toggle.
- Reset mid-hold: drive `rst_n` low during the REPEAT state → all outputs 0 immediately; after release of reset with the button still held, a single new press pulse after 6 edges.
- Multi-channel: all 4 channels pressed on the same cycle → `button_one_shot` = 4'b1111 for one cycle.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioner: edge-mode selectors,
// repeat FSM state encoding and a small elaboration-time helper.
package button_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability-counter debounce,
// registered edge pulse and optional hold-to-repeat FSM.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = 500000,
  parameter int EDGE_MODE     = 0,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_level,
  output logic o_pulse
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int RP_W  = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam bit RP_ON = (REPEAT_EN != 0) && (EDGE_MODE != EDGE_FALL);

  logic            r_sync0;
  logic            r_sync1;
  logic            r_level;
  logic            r_pulse;
  logic [DB_W-1:0] r_db_cnt;
  logic [1:0]      r_state;
  logic [RP_W-1:0] r_rp_cnt;

  logic            w_s;
  logic            w_diff;
  logic            w_toggle;
  logic            w_rise;
  logic            w_fall;
  logic            w_edge_pulse;
  logic            w_rp_fire;
  logic [1:0]      w_state_nxt;
  logic [RP_W-1:0] w_rp_cnt_nxt;

  assign w_s      = (ACTIVE_LOW != 0) ? ~r_sync1 : r_sync1;
  assign w_diff   = (w_s != r_level);
  // Toggle on the edge where the count would reach DB_CYCLES.
  assign w_toggle = w_diff && (r_db_cnt == DB_W'(DB_CYCLES - 1));
  assign w_rise   = w_toggle & ~r_level;
  assign w_fall   = w_toggle & r_level;

  always_comb begin
    w_edge_pulse = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: w_edge_pulse = w_rise;
      EDGE_FALL: w_edge_pulse = w_fall;
      default:   w_edge_pulse = w_toggle;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rp_cnt_nxt = r_rp_cnt;
    w_rp_fire    = 1'b0;
    if (RP_ON) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt  = ST_HOLD;
            w_rp_cnt_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (w_fall) begin
            w_state_nxt  = ST_IDLE;
            w_rp_cnt_nxt = '0;
          end else if (r_rp_cnt == RP_W'(REPEAT_DELAY - 1)) begin
            w_rp_fire    = 1'b1;
            w_state_nxt  = ST_REPEAT;
            w_rp_cnt_nxt = '0;
          end else begin
            w_rp_cnt_nxt = r_rp_cnt + RP_W'(1);
          end
        end
        ST_REPEAT: begin
          if (w_fall) begin
            w_state_nxt  = ST_IDLE;
            w_rp_cnt_nxt = '0;
          end else if (r_rp_cnt == RP_W'(REPEAT_PERIOD - 1)) begin
            w_rp_fire    = 1'b1;
            w_rp_cnt_nxt = '0;
          end else begin
            w_rp_cnt_nxt = r_rp_cnt + RP_W'(1);
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_rp_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_level  <= 1'b0;
      r_pulse  <= 1'b0;
      r_db_cnt <= '0;
      r_state  <= ST_IDLE;
      r_rp_cnt <= '0;
    end else begin
      r_sync0  <= i_button;
      r_sync1  <= r_sync0;
      r_pulse  <= w_edge_pulse | w_rp_fire;
      r_state  <= w_state_nxt;
      r_rp_cnt <= w_rp_cnt_nxt;
      if (!w_diff || w_toggle) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_toggle) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/multi_debounce_one_shot.sv
// N-channel button conditioner: one independent debounce_channel per input,
// outputs concatenated bit-for-bit.
module multi_debounce_one_shot
  import button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int EDGE_MODE     = 0,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] button_level,
  output logic [N_CH-1:0] button_one_shot
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .EDGE_MODE     (EDGE_MODE),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_button (button[g]),
      .o_level  (button_level[g]),
      .o_pulse  (button_one_shot[g])
    );
  end

endmodule

// File: tb/tb_multi_debounce_one_shot.sv
// Directed bench: three configurations (press-only, both-edge, repeat) with
// DB_CYCLES=4, so each debounced edge lands 6 clock edges after the raw change.
module tb_multi_debounce_one_shot;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_a, btn_b, btn_c;
  logic [3:0] lvl_a, lvl_b, lvl_c;
  logic [3:0] os_a, os_b, os_c;

  int n_checks = 0;
  int n_errors = 0;

  multi_debounce_one_shot #(
    .N_CH(4), .DB_CYCLES(4), .EDGE_MODE(0), .ACTIVE_LOW(0),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .button(btn_a),
    .button_level(lvl_a), .button_one_shot(os_a)
  );

  multi_debounce_one_shot #(
    .N_CH(4), .DB_CYCLES(4), .EDGE_MODE(2), .ACTIVE_LOW(0),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .button(btn_b),
    .button_level(lvl_b), .button_one_shot(os_b)
  );

  multi_debounce_one_shot #(
    .N_CH(4), .DB_CYCLES(4), .EDGE_MODE(0), .ACTIVE_LOW(0),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .button(btn_c),
    .button_level(lvl_c), .button_one_shot(os_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 4'b0000;
    btn_b = 4'b0000;
    btn_c = 4'b0000;
    repeat (3) step();
    check_eq("rst_lvl_a", {28'd0, lvl_a}, 32'h0);
    check_eq("rst_os_a",  {28'd0, os_a},  32'h0);
    check_eq("rst_lvl_c", {28'd0, lvl_c}, 32'h0);
    check_eq("rst_os_c",  {28'd0, os_c},  32'h0);
    rst_n = 1'b1;
    repeat (3) step();

    // Clean press on ch0, held 20 cycles
    btn_a[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_eq($sformatf("press_os_k%0d", k),  {28'd0, os_a},  (k == 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("press_lvl_k%0d", k), {28'd0, lvl_a}, (k >= 6) ? 32'h1 : 32'h0);
    end
    btn_a[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("rel_a_os_k%0d", k), {28'd0, os_a}, 32'h0);
    end
    check_eq("rel_a_lvl", {28'd0, lvl_a}, 32'h0);

    // Bounce on ch1: 1,0,1,0 for 2 cycles each, then hold 1
    for (int b = 0; b < 4; b++) begin
      btn_a[1] = (b % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step();
        check_eq($sformatf("bounce_os_b%0d_%0d", b, k),  {28'd0, os_a},  32'h0);
        check_eq($sformatf("bounce_lvl_b%0d_%0d", b, k), {28'd0, lvl_a}, 32'h0);
      end
    end
    btn_a[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq($sformatf("bounce_hold_os_k%0d", k),  {28'd0, os_a},  (k == 6) ? 32'h2 : 32'h0);
      check_eq($sformatf("bounce_hold_lvl_k%0d", k), {28'd0, lvl_a}, (k >= 6) ? 32'h2 : 32'h0);
    end
    btn_a[1] = 1'b0;
    repeat (10) step();
    check_eq("bounce_rel_lvl", {28'd0, lvl_a}, 32'h0);

    // All four channels pressed together
    btn_a = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_eq($sformatf("multi_os_k%0d", k), {28'd0, os_a}, (k == 6) ? 32'hF : 32'h0);
    end
    check_eq("multi_lvl", {28'd0, lvl_a}, 32'hF);
    btn_a = 4'b0000;
    repeat (10) step();

    // Both-edge mode on ch2: press 10 cycles, release 10 cycles
    btn_b[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("both_press_os_k%0d", k),  {28'd0, os_b},  (k == 6) ? 32'h4 : 32'h0);
      check_eq($sformatf("both_press_lvl_k%0d", k), {28'd0, lvl_b}, (k >= 6) ? 32'h4 : 32'h0);
    end
    btn_b[2] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("both_rel_os_k%0d", k),  {28'd0, os_b},  (k == 6) ? 32'h4 : 32'h0);
      check_eq($sformatf("both_rel_lvl_k%0d", k), {28'd0, lvl_b}, (k >= 6) ? 32'h0 : 32'h4);
    end

    // Hold-to-repeat on ch3: held 40 cycles; press pulse at 6, repeats at 16,21,...,41
    btn_c[3] = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      step();
      check_eq($sformatf("rep_os_k%0d", k), {28'd0, os_c},
               ((k == 6) || (k >= 16 && k < 46 && (k - 16) % 5 == 0)) ? 32'h8 : 32'h0);
      check_eq($sformatf("rep_lvl_k%0d", k), {28'd0, lvl_c},
               (k >= 6 && k < 46) ? 32'h8 : 32'h0);
      if (k == 40) btn_c[3] = 1'b0;
    end

    // Reset asserted while in REPEAT, then released with the button still held
    btn_c[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_eq($sformatf("prerst_os_k%0d", k), {28'd0, os_c},
               (k == 6 || k == 16) ? 32'h8 : 32'h0);
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_lvl", {28'd0, lvl_c}, 32'h0);
    check_eq("midrst_os",  {28'd0, os_c},  32'h0);
    repeat (3) step();
    check_eq("inrst_lvl", {28'd0, lvl_c}, 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq($sformatf("postrst_os_k%0d", k),  {28'd0, os_c},  (k == 6) ? 32'h8 : 32'h0);
      check_eq($sformatf("postrst_lvl_k%0d", k), {28'd0, lvl_c}, (k >= 6) ? 32'h8 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
